// File: rtl/random_pool.sv
`default_nettype none
// -----------------------------------------------------------------------------
// random_pool : Galois-LFSR word source with FIFO buffer and repetition test
// Rev 1.0
// -----------------------------------------------------------------------------
module random_pool #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int REP_LIMIT = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [31:0]                i_seed,
  input  logic                       i_seed_load,
  input  logic                       i_enable,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_overflow,
  output logic                       o_health_fail
);

  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DATA_W+1);
  localparam int REP_W = $clog2(REP_LIMIT+1);
  localparam logic [31:0]      c_lfsr_mask = 32'h8020_0003;
  localparam logic [CNT_W-1:0] c_last_bit  = CNT_W'(DATA_W-1);
  localparam logic [REP_W-1:0] c_rep_limit = REP_W'(REP_LIMIT);
  localparam logic [LVL_W-1:0] c_depth     = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FAIL = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic [31:0]        r_lfsr, w_lfsr_next;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0]  r_word, r_prev_word, w_word_next;
  logic [REP_W-1:0]   r_rep_cnt, w_rep_next;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_overflow;
  logic               w_step, w_complete, w_trip, w_push, w_pop, w_full, w_wr_en;

  assign w_step      = (r_state == S_RUN) && i_enable && !i_seed_load && !i_reset;
  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_lfsr_mask : 32'h0);
  // Truncating the concatenation keeps the newest bit in the LSB for any DATA_W
  assign w_word_next = DATA_W'({r_word, r_lfsr[0]});
  assign w_complete  = w_step && (r_bit_cnt == c_last_bit);
  assign w_rep_next  = ((r_rep_cnt != '0) && (w_word_next == r_prev_word)) ?
                       r_rep_cnt + 1'b1 : REP_W'(1);
  assign w_trip      = w_complete && (w_rep_next >= c_rep_limit);
  assign w_push      = w_complete && !w_trip;
  assign w_full      = (r_level == c_depth);
  assign w_pop       = (r_level != '0) && i_ready;
  assign w_wr_en     = w_push && (!w_full || w_pop);

  always_comb begin
    w_state_next = r_state;
    if (i_seed_load)
      w_state_next = S_RUN;
    else if (w_trip)
      w_state_next = S_FAIL;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lfsr      <= 32'h1;
      r_bit_cnt   <= '0;
      r_word      <= '0;
      r_prev_word <= '0;
      r_rep_cnt   <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
    end else if (i_seed_load) begin
      r_lfsr      <= (i_seed == 32'h0) ? 32'h1 : i_seed;
      r_bit_cnt   <= '0;
      r_word      <= '0;
      r_rep_cnt   <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
    end else if (w_trip) begin
      // Failing word is never pushed and the buffer is emptied
      r_lfsr      <= w_lfsr_next;
      r_bit_cnt   <= '0;
      r_word      <= w_word_next;
      r_prev_word <= w_word_next;
      r_rep_cnt   <= w_rep_next;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
    end else begin
      if (w_step) begin
        r_lfsr    <= w_lfsr_next;
        r_word    <= w_word_next;
        r_bit_cnt <= w_complete ? '0 : r_bit_cnt + 1'b1;
      end
      if (w_complete) begin
        r_rep_cnt   <= w_rep_next;
        r_prev_word <= w_word_next;
      end
      if (w_wr_en)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_push && w_full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr] <= w_word_next;
  end

  assign o_valid       = (r_level != '0);
  assign o_data        = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_level       = r_level;
  assign o_overflow    = r_overflow;
  assign o_health_fail = (r_state == S_FAIL);

endmodule
`default_nettype wire
